// File: rtl/dither_demod_v1.sv
// Dither demodulator: blanks each dither half, averages 2^avg_sel samples, emits (H-L)/2 and (H+L)/2.
// Latency 4 edges from final L trigger to o_valid; no backpressure, o_valid is a one-cycle strobe.
module dither_demod_v1 #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 42,
  parameter int WAIT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_trig,
  input  logic [DATA_W-1:0] i_dither,
  input  logic [DATA_W-1:0] i_data,
  input  logic [WAIT_W-1:0] i_wait_cnt,
  input  logic [3:0]        i_avg_sel,
  output logic [DATA_W-1:0] o_err,
  output logic [DATA_W-1:0] o_dc,
  output logic              o_valid,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BLANK = 3'd1,
    ACQ   = 3'd2,
    DONE  = 3'd3,
    MEAN  = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam int CNT_W = (WAIT_W > 11) ? WAIT_W : 11;

  state_t                   state, state_nxt;
  logic                     trig_r, pol_r, pol_prev;
  logic [DATA_W-1:0]        data_r;
  logic                     chg;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic [CNT_W-1:0]         cnt;
  logic                     half, got_h, out_pend;
  logic [3:0]               shift, shift_sel;
  logic [DATA_W-1:0]        reg_h, reg_l, mean;
  logic [DATA_W:0]          err_sum, dc_sum;
  logic                     unused_bits;

  assign chg       = (pol_r != pol_prev);
  assign shift_sel = (i_avg_sel > 4'd10) ? 4'd7 : i_avg_sel;
  assign acc_sh    = acc >>> shift;
  assign mean      = acc_sh[DATA_W-1:0];
  // One extra bit so the difference/sum can never wrap before halving.
  assign err_sum   = {reg_h[DATA_W-1], reg_h} - {reg_l[DATA_W-1], reg_l};
  assign dc_sum    = {reg_h[DATA_W-1], reg_h} + {reg_l[DATA_W-1], reg_l};
  assign o_state   = state;
  assign unused_bits = ^{i_dither[DATA_W-2:0], acc_sh[ACC_W-1:DATA_W], err_sum[0], dc_sum[0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (chg) begin
      state_nxt = BLANK;
    end else begin
      case (state)
        BLANK:   if (cnt == '0) state_nxt = ACQ;
        ACQ:     if (trig_r && cnt == CNT_W'(1)) state_nxt = DONE;
        DONE:    state_nxt = MEAN;
        MEAN:    state_nxt = HOLD;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      trig_r   <= 1'b0;
      data_r   <= '0;
      pol_r    <= 1'b1;
      pol_prev <= 1'b1;
      acc      <= '0;
      cnt      <= '0;
      half     <= 1'b1;
      shift    <= '0;
      got_h    <= 1'b0;
      reg_h    <= '0;
      reg_l    <= '0;
      out_pend <= 1'b0;
      o_err    <= '0;
      o_dc     <= '0;
      o_valid  <= 1'b0;
    end else begin
      trig_r   <= i_trig;
      data_r   <= i_data;
      pol_r    <= i_dither[DATA_W-1];
      pol_prev <= pol_r;
      out_pend <= 1'b0;
      o_valid  <= 1'b0;

      // The MEAN store completes even if a polarity change lands on the same cycle.
      if (state == MEAN) begin
        if (!half) begin
          reg_h <= mean;
          got_h <= 1'b1;
        end else if (got_h) begin
          reg_l    <= mean;
          out_pend <= 1'b1;
          got_h    <= 1'b0;
        end
      end

      if (chg) begin
        half  <= pol_r;
        shift <= shift_sel;
        cnt   <= CNT_W'(i_wait_cnt);
        if (!pol_r) got_h <= 1'b0;
      end else begin
        case (state)
          BLANK: begin
            if (cnt == '0) begin
              cnt <= CNT_W'(1) << shift;
              acc <= '0;
            end else if (trig_r) begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ACQ: begin
            if (trig_r) begin
              acc <= acc + {{(ACC_W-DATA_W){data_r[DATA_W-1]}}, data_r};
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end

      if (out_pend) begin
        o_err   <= err_sum[DATA_W:1];
        o_dc    <= dc_sum[DATA_W:1];
        o_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dither_demod_v1.sv
// Directed bench for dither_demod_v1: hand-computed H/L averages, abort, discard and reset cases.
module tb_dither_demod_v1;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 42;
  localparam int WAIT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trig = 1'b0;
  logic [DATA_W-1:0] dither = '1;
  logic [DATA_W-1:0] data = '0;
  logic [WAIT_W-1:0] wait_cnt = '0;
  logic [3:0]        avg_sel = '0;
  logic [DATA_W-1:0] err, dc;
  logic              valid;
  logic [2:0]        state;

  int errors = 0, checks = 0;
  int valid_cnt = 0, run = 0, max_run = 0;
  int cyc = 0, valid_cyc = 0, trig_cyc = 0;

  dither_demod_v1 #(.DATA_W(DATA_W), .ACC_W(ACC_W), .WAIT_W(WAIT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_trig(trig), .i_dither(dither), .i_data(data),
    .i_wait_cnt(wait_cnt), .i_avg_sel(avg_sel),
    .o_err(err), .o_dc(dc), .o_valid(valid), .o_state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic pulse(input int d);
    @(negedge clk);
    data = d;
    trig = 1'b1;
    trig_cyc = cyc + 1;
    @(negedge clk);
    trig = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulses(input int n, input int d);
    for (int i = 0; i < n; i++) pulse(d);
  endtask

  task automatic set_dither(input bit h);
    @(negedge clk);
    dither = h ? 32'sd1 : -32'sd1;
    repeat (4) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_err", err, 0);
    check("rst_dc", dc, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_state", {29'd0, state}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1: wait=2, N=4, H=100, L=-20
    wait_cnt = 16'd2;
    avg_sel = 4'd2;
    set_dither(1'b1);
    check("t1_blank_state", {29'd0, state}, 1);
    pulses(2, 999);
    check("t1_acq_state", {29'd0, state}, 2);
    pulses(4, 100);
    idle(6);
    check("t1_no_valid_h", valid_cnt, 0);
    check("t1_hold_state", {29'd0, state}, 5);
    set_dither(1'b0);
    pulses(2, 999);
    pulses(4, -20);
    idle(6);
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_err", err, 60);
    check("t1_dc", dc, 40);

    // 2: wait=0, N=1, H=7, L=2, latency
    wait_cnt = 16'd0;
    avg_sel = 4'd0;
    set_dither(1'b1);
    pulse(7);
    idle(6);
    check("t2_hold_err", err, 60);
    check("t2_hold_dc", dc, 40);
    check("t2_no_valid_h", valid_cnt, 1);
    set_dither(1'b0);
    pulse(2);
    idle(6);
    check("t2_valid_cnt", valid_cnt, 2);
    check("t2_latency", valid_cyc - trig_cyc, 4);
    check("t2_err", err, 2);
    check("t2_dc", dc, 4);

    // 3: floor toward -inf, H=-3, L=0
    set_dither(1'b1);
    pulse(-3);
    idle(6);
    set_dither(1'b0);
    pulse(0);
    idle(6);
    check("t3_valid_cnt", valid_cnt, 3);
    check("t3_err", err, -2);
    check("t3_dc", dc, -2);

    // 4: H aborted after 2 of 4, orphan L discarded, then H=10 L=2
    avg_sel = 4'd2;
    set_dither(1'b1);
    pulses(2, 10);
    set_dither(1'b0);
    pulses(4, 50);
    idle(6);
    check("t4_no_valid_abort", valid_cnt, 3);
    set_dither(1'b1);
    pulses(4, 10);
    idle(6);
    set_dither(1'b0);
    pulses(4, 2);
    idle(6);
    check("t4_valid_cnt", valid_cnt, 4);
    check("t4_err", err, 4);
    check("t4_dc", dc, 6);

    // 5: avg_sel=13 clamps to N=128
    avg_sel = 4'd13;
    set_dither(1'b1);
    pulses(128, 5);
    idle(6);
    set_dither(1'b0);
    pulses(127, 1);
    idle(6);
    check("t5_no_valid_127", valid_cnt, 4);
    check("t5_still_acq", {29'd0, state}, 2);
    pulse(1);
    idle(6);
    check("t5_valid_cnt", valid_cnt, 5);
    check("t5_err", err, 2);
    check("t5_dc", dc, 3);

    // 6: reset in the middle of the L half
    avg_sel = 4'd2;
    set_dither(1'b1);
    pulses(4, 8);
    idle(6);
    set_dither(1'b0);
    pulses(2, 4);
    check("t6_acq_l", {29'd0, state}, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_err", err, 0);
    check("t6_rst_dc", dc, 0);
    check("t6_rst_state", {29'd0, state}, 0);
    check("t6_rst_valid", {31'd0, valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse(9);
    idle(4);
    check("t6_idle", {29'd0, state}, 0);
    set_dither(1'b1);
    set_dither(1'b0);
    pulses(4, 4);
    idle(6);
    check("t6_l_only_no_valid", valid_cnt, 5);
    check("t6_hold_zero", err, 0);
    set_dither(1'b1);
    pulses(4, 6);
    idle(6);
    set_dither(1'b0);
    pulses(4, 2);
    idle(6);
    check("t6_valid_cnt", valid_cnt, 6);
    check("t6_err", err, 2);
    check("t6_dc", dc, 4);
    check("valid_width", max_run, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
